// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_tx_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam int   MIN_DATA_LEN = 5;
  localparam logic PAR_EVEN     = 1'b0;
  localparam logic PAR_ODD      = 1'b1;
  localparam logic STOP_ONE     = 1'b0;
  localparam logic STOP_TWO     = 1'b1;

  // Out-of-range length requests saturate to the supported window.
  function automatic logic [3:0] clamp_len(input logic [3:0] req, input int max_len);
    if (req < 4'(MIN_DATA_LEN)) return 4'(MIN_DATA_LEN);
    else if (int'(req) > max_len) return 4'(max_len);
    else return req;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous TX FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign full     = (level == LVL_W'(DEPTH));
  assign empty    = (level == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Depth is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// Buffered UART transmitter: FIFO-fed frame serialiser with parity and 1/2 stop bits.
// Optional line-break support is enabled with the UART_TX_BREAK_EN macro.
module uart_tx_engine
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 9,
  parameter int FIFO_DEPTH = 8,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clken,
  input  logic                  cts_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [3:0]            cfg_data_len,
  input  logic                  cfg_stop_bit_num,
  input  logic                  cfg_parity_en,
  input  logic                  cfg_parity_type,
  input  logic                  host_read_stt_tx_done,
`ifdef UART_TX_BREAK_EN
  input  logic                  break_req,
`endif
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic [LVL_W-1:0]      fifo_level,
  output logic                  stt_overflow,
  output logic                  stt_tx_done,
  output logic                  tx_busy,
  output logic                  tx
);

  state_t                state;
  logic [DATA_WIDTH-1:0] head, shift_q;
  logic [3:0]            bit_cnt, len_q, cfg_len;
  logic                  stop2_q, par_en_q, par_bit_q, stop_cnt;
  logic                  head_par, frame_end, start_ok, pop, brk_q, brk_req_w;

`ifdef UART_TX_BREAK_EN
  assign brk_req_w = break_req;
`else
  assign brk_req_w = 1'b0;
`endif

  uart_tx_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Parity is fixed at pop time from the head word and the length it will be sent with.
  always_comb begin
    cfg_len  = clamp_len(cfg_data_len, DATA_WIDTH);
    head_par = (cfg_parity_type == PAR_ODD);
    for (int i = 0; i < DATA_WIDTH; i++)
      if (i < int'(cfg_len)) head_par = head_par ^ head[i];
  end

  assign frame_end = (state == STOP) && (stop_cnt == stop2_q);
  assign start_ok  = !fifo_empty && !cts_n && !brk_req_w && !brk_q;
  assign pop       = clken && start_ok && ((state == IDLE) || frame_end);
  assign tx_busy   = (state != IDLE) || brk_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      tx           <= 1'b1;
      shift_q      <= '0;
      bit_cnt      <= '0;
      len_q        <= 4'(MIN_DATA_LEN);
      stop2_q      <= STOP_ONE;
      par_en_q     <= 1'b0;
      par_bit_q    <= PAR_EVEN;
      stop_cnt     <= 1'b0;
      brk_q        <= 1'b0;
      stt_tx_done  <= 1'b1;
      stt_overflow <= 1'b0;
    end else begin
      if (wr_en && fifo_full && !pop) stt_overflow <= 1'b1;
      if (host_read_stt_tx_done) stt_tx_done <= 1'b0;
      if (clken) begin
        case (state)
          IDLE: begin
            if (brk_req_w) begin
              tx    <= 1'b0;
              brk_q <= 1'b1;
            end else begin
              tx    <= 1'b1;
              brk_q <= 1'b0;
            end
          end
          START: begin
            tx      <= shift_q[0];
            bit_cnt <= 4'd1;
            state   <= DATA;
          end
          DATA: begin
            if (bit_cnt < len_q) begin
              shift_q <= shift_q >> 1;
              tx      <= shift_q[1];
              bit_cnt <= bit_cnt + 4'd1;
            end else if (par_en_q) begin
              tx    <= par_bit_q;
              state <= PARITY;
            end else begin
              tx       <= 1'b1;
              stop_cnt <= 1'b0;
              state    <= STOP;
            end
          end
          PARITY: begin
            tx       <= 1'b1;
            stop_cnt <= 1'b0;
            state    <= STOP;
          end
          STOP: begin
            tx <= 1'b1;
            if (frame_end) begin
              state       <= IDLE;
              stt_tx_done <= 1'b1;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
        // A pop overrides the idle/stop-end outcome above, giving zero-gap back-to-back frames.
        if (pop) begin
          shift_q   <= head;
          len_q     <= cfg_len;
          stop2_q   <= (cfg_stop_bit_num == STOP_TWO);
          par_en_q  <= cfg_parity_en;
          par_bit_q <= head_par;
          tx        <= 1'b0;
          state     <= START;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed self-checking bench for uart_tx_engine; covers the break feature when UART_TX_BREAK_EN is defined.
module tb_uart_tx_engine;

  localparam int DW = 9;
  localparam int FD = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          clken = 1'b0;
  logic          cts_n = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [3:0]    cfg_data_len = 4'd8;
  logic          cfg_stop_bit_num = 1'b0;
  logic          cfg_parity_en = 1'b0;
  logic          cfg_parity_type = 1'b0;
  logic          host_read = 1'b0;
`ifdef UART_TX_BREAK_EN
  logic          break_req = 1'b0;
`endif
  logic          fifo_full, fifo_empty, stt_overflow, stt_tx_done, tx_busy, tx;
  logic [LW-1:0] fifo_level;

  int total = 0;
  int bad = 0;

  uart_tx_engine #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .clken                 (clken),
    .cts_n                 (cts_n),
    .wr_en                 (wr_en),
    .wr_data               (wr_data),
    .cfg_data_len          (cfg_data_len),
    .cfg_stop_bit_num      (cfg_stop_bit_num),
    .cfg_parity_en         (cfg_parity_en),
    .cfg_parity_type       (cfg_parity_type),
    .host_read_stt_tx_done (host_read),
`ifdef UART_TX_BREAK_EN
    .break_req             (break_req),
`endif
    .fifo_full             (fifo_full),
    .fifo_empty            (fifo_empty),
    .fifo_level            (fifo_level),
    .stt_overflow          (stt_overflow),
    .stt_tx_done           (stt_tx_done),
    .tx_busy               (tx_busy),
    .tx                    (tx)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One baud period: clken high for a single clock, outputs then sampled at a falling edge.
  task automatic applyStimulus();
    @(negedge clk);
    clken = 1'b1;
    @(negedge clk);
    clken = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pushWord(input logic [DW-1:0] w);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = w;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic clearDone();
    @(negedge clk);
    host_read = 1'b1;
    @(negedge clk);
    host_read = 1'b0;
  endtask

  // exp[i] is the line level expected after the (i+1)th tick; one extra tick must end the frame.
  task automatic runFrame(input string tag, input logic [15:0] exp, input int n);
    clearDone();
    checkOutput({tag, " done_clr"}, 32'(stt_tx_done), 32'd0);
    for (int i = 0; i < n; i++) begin
      applyStimulus();
      checkOutput($sformatf("%s tx%0d", tag, i), 32'(tx), 32'(exp[i]));
      checkOutput($sformatf("%s busy%0d", tag, i), 32'(tx_busy), 32'd1);
    end
    applyStimulus();
    checkOutput({tag, " end_tx"}, 32'(tx), 32'd1);
    checkOutput({tag, " end_busy"}, 32'(tx_busy), 32'd0);
    checkOutput({tag, " end_done"}, 32'(stt_tx_done), 32'd1);
  endtask

  initial begin
    logic [DW-1:0] w;
    logic          e;
    logic [15:0]   exp5a;

    $display("[TB] reset state");
    repeat (3) @(negedge clk);
    checkOutput("rst tx", 32'(tx), 32'd1);
    checkOutput("rst empty", 32'(fifo_empty), 32'd1);
    checkOutput("rst full", 32'(fifo_full), 32'd0);
    checkOutput("rst level", 32'(fifo_level), 32'd0);
    checkOutput("rst ovf", 32'(stt_overflow), 32'd0);
    checkOutput("rst done", 32'(stt_tx_done), 32'd1);
    checkOutput("rst busy", 32'(tx_busy), 32'd0);
    reset_n = 1'b1;

    $display("[TB] 8N1 frame 0xA5");
    cts_n = 1'b0;
    pushWord(9'h0A5);
    checkOutput("t1 level", 32'(fifo_level), 32'd1);
    checkOutput("t1 empty", 32'(fifo_empty), 32'd0);
    checkOutput("t1 idle_tx", 32'(tx), 32'd1);
    runFrame("t1", 16'b11_0100_1010, 10);
    checkOutput("t1 empty_end", 32'(fifo_empty), 32'd1);

    $display("[TB] 7O2 frame 0x03");
    cfg_data_len = 4'd7; cfg_parity_en = 1'b1; cfg_parity_type = 1'b1; cfg_stop_bit_num = 1'b1;
    pushWord(9'h003);
    runFrame("t2", 16'b111_0000_0110, 11);

    $display("[TB] 9E1 frame 0x1FF");
    cfg_data_len = 4'd9; cfg_parity_type = 1'b0; cfg_stop_bit_num = 1'b0;
    pushWord(9'h1FF);
    runFrame("t3", 16'b1111_1111_1110, 12);

    $display("[TB] oversized length request saturates");
    cfg_data_len = 4'd15;
    pushWord(9'h1FF);
    runFrame("t3b", 16'b1111_1111_1110, 12);

    $display("[TB] fill, overflow, back-to-back drain");
    cfg_data_len = 4'd8; cfg_parity_en = 1'b0; cts_n = 1'b1;
    for (int i = 0; i < 8; i++) pushWord(9'(16 + i));
    checkOutput("t4 ovf_pre", 32'(stt_overflow), 32'd0);
    checkOutput("t4 full", 32'(fifo_full), 32'd1);
    checkOutput("t4 level8", 32'(fifo_level), 32'd8);
    pushWord(9'h0FF);
    checkOutput("t4 ovf", 32'(stt_overflow), 32'd1);
    checkOutput("t4 level_hold", 32'(fifo_level), 32'd8);
    repeat (3) applyStimulus();
    checkOutput("t4 cts_tx", 32'(tx), 32'd1);
    checkOutput("t4 cts_busy", 32'(tx_busy), 32'd0);
    checkOutput("t4 cts_level", 32'(fifo_level), 32'd8);
    cts_n = 1'b0;
    for (int t = 0; t < 80; t++) begin
      applyStimulus();
      w = 9'(16 + t / 10);
      if (t % 10 == 0) e = 1'b0;
      else if (t % 10 == 9) e = 1'b1;
      else e = w[t % 10 - 1];
      checkOutput($sformatf("t4 tx%0d", t), 32'(tx), 32'(e));
      checkOutput($sformatf("t4 busy%0d", t), 32'(tx_busy), 32'd1);
      if (t == 0) checkOutput("t4 level7", 32'(fifo_level), 32'd7);
    end
    applyStimulus();
    checkOutput("t4 end_busy", 32'(tx_busy), 32'd0);
    checkOutput("t4 end_tx", 32'(tx), 32'd1);
    checkOutput("t4 end_empty", 32'(fifo_empty), 32'd1);
    checkOutput("t4 end_level", 32'(fifo_level), 32'd0);
    checkOutput("t4 ovf_sticky", 32'(stt_overflow), 32'd1);

    $display("[TB] mid-frame config and cts changes");
    pushWord(9'h05A);
    pushWord(9'h013);
    exp5a = 16'b10_1011_0100;
    for (int i = 0; i < 10; i++) begin
      applyStimulus();
      checkOutput($sformatf("t5a tx%0d", i), 32'(tx), 32'(exp5a[i]));
      if (i == 2) begin
        cfg_data_len = 4'd5;
        cts_n = 1'b1;
      end
    end
    applyStimulus();
    checkOutput("t5 gap_busy", 32'(tx_busy), 32'd0);
    checkOutput("t5 gap_tx", 32'(tx), 32'd1);
    checkOutput("t5 gap_level", 32'(fifo_level), 32'd1);
    repeat (2) applyStimulus();
    checkOutput("t5 wait_tx", 32'(tx), 32'd1);
    checkOutput("t5 wait_busy", 32'(tx_busy), 32'd0);
    cts_n = 1'b0;
    runFrame("t5b", 16'b110_0110, 7);
    checkOutput("t5 empty", 32'(fifo_empty), 32'd1);

    $display("[TB] reset during DATA");
    cfg_data_len = 4'd8;
    pushWord(9'h000);
    pushWord(9'h0AA);
    clearDone();
    repeat (3) applyStimulus();
    checkOutput("t6 pre_tx", 32'(tx), 32'd0);
    checkOutput("t6 pre_busy", 32'(tx_busy), 32'd1);
    checkOutput("t6 pre_level", 32'(fifo_level), 32'd1);
    checkOutput("t6 pre_done", 32'(stt_tx_done), 32'd0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("t6 rst_tx", 32'(tx), 32'd1);
    checkOutput("t6 rst_level", 32'(fifo_level), 32'd0);
    checkOutput("t6 rst_empty", 32'(fifo_empty), 32'd1);
    checkOutput("t6 rst_done", 32'(stt_tx_done), 32'd1);
    checkOutput("t6 rst_busy", 32'(tx_busy), 32'd0);
    checkOutput("t6 rst_ovf", 32'(stt_overflow), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) applyStimulus();
    checkOutput("t6 post_tx", 32'(tx), 32'd1);
    checkOutput("t6 post_busy", 32'(tx_busy), 32'd0);

`ifdef UART_TX_BREAK_EN
    $display("[TB] line break");
    @(negedge clk);
    break_req = 1'b1;
    pushWord(9'h055);
    for (int i = 0; i < 20; i++) begin
      applyStimulus();
      checkOutput($sformatf("t7 brk_tx%0d", i), 32'(tx), 32'd0);
      checkOutput($sformatf("t7 brk_busy%0d", i), 32'(tx_busy), 32'd1);
      checkOutput($sformatf("t7 brk_level%0d", i), 32'(fifo_level), 32'd1);
    end
    break_req = 1'b0;
    applyStimulus();
    checkOutput("t7 rel_tx", 32'(tx), 32'd1);
    checkOutput("t7 rel_busy", 32'(tx_busy), 32'd0);
    checkOutput("t7 rel_level", 32'(fifo_level), 32'd1);
    runFrame("t7", 16'b10_1010_1010, 10);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
Parametrised successor to the UART transmitter: buffered, configurable-width serial transmitter with a true parity bit and a host-side TX FIFO.
- Host pushes words into an internal FIFO. The engine pops them and serialises each frame as start, N data bits (LSB first), optional parity, then 1 or 2 stops.
- One bit per clken tick, gated by cts_n.
- Sits between the APB/register block and the uart pin mux; clken comes from the shared baud generator.

Parameters:
- DATA_WIDTH, 9, maximum data bits per frame (5..9 supported).
- FIFO_DEPTH, 8, TX FIFO entries; power of two, >= 2.
- LVL_W, $clog2(FIFO_DEPTH)+1, width of fifo_level (derived; do not override).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- clken  input  1  baud tick, one-cycle pulse per bit period
- cts_n  input  1  clear-to-send, active low; sampled only at frame start
- wr_en  input  1  host push strobe
- wr_data  input  DATA_WIDTH  word to push
- cfg_data_len  input  4  data bits per frame; 5..DATA_WIDTH; <5 treated as 5, >DATA_WIDTH as DATA_WIDTH
- cfg_stop_bit_num  input  1  0 = 1 stop, 1 = 2 stops
- cfg_parity_en  input  1  1 = insert parity bit
- cfg_parity_type  input  1  0 = even, 1 = odd
- host_read_stt_tx_done  input  1  clears stt_tx_done
- fifo_full  output  1  FIFO holds FIFO_DEPTH words
- fifo_empty  output  1  FIFO holds 0 words
- fifo_level  output  LVL_W  current word count
- stt_overflow  output  1  sticky; push attempted while full
- stt_tx_done  output  1  sticky; last stop bit of a frame completed
- tx_busy  output  1  FSM not in IDLE
- tx  output  1  serial line, registered

Behaviour:
- Reset values: tx=1, fifo_empty=1, fifo_full=0, fifo_level=0, stt_overflow=0, stt_tx_done=1, tx_busy=0, FSM=IDLE. FIFO contents are discarded.
- Reset mid-frame: tx returns high immediately (async); the partial frame is lost.
- FSM states: IDLE, START, DATA, PARITY, STOP. All transitions happen only on cycles with clken=1.
- IDLE:
  - If !fifo_empty && !cts_n && clken: pop the head into the shift register, latch cfg_* into frame registers, set tx=0, go START.
  - Otherwise tx=1.
- START: on clken, tx=shift[0], bit counter=1, go DATA.
- DATA:
  - On clken with counter < latched len: shift right, tx=next bit, counter+1.
  - On clken with counter == len: if parity enabled, tx=parity, go PARITY; else tx=1, go STOP.
- PARITY: on clken, tx=1, go STOP.
- STOP: on clken, count stop bits.
  - After the latched count (1 or 2) has elapsed, return to IDLE.
  - A back-to-back frame may start on that same clken if the IDLE start conditions hold (zero idle gap).
- Each bit occupies exactly one clken period; tx changes only on clken cycles.
- Parity is computed over the latched len bits only: even = XOR of those bits; odd = inverted XOR.
- Config changes mid-frame have no effect until the next frame.
- cts_n deasserting mid-frame does not abort; the current frame completes.
- FIFO push accepted when wr_en && (!fifo_full || pop in the same cycle).
- Push while full with no pop: word dropped, stt_overflow set. stt_overflow clears only on reset.
- Simultaneous push and pop: fifo_level unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- stt_tx_done:
  - Set on the clken that ends the final stop bit.
  - Cleared by host_read_stt_tx_done; set wins if both occur in the same cycle.
- tx_busy = (state != IDLE).

Optional Feature:
- Macro UART_TX_BREAK_EN.
- Defined:
  - Adds input break_req (1). When break_req=1 and FSM in IDLE, at the next clken tx is driven 0 and held.
  - The FIFO is not popped and tx_busy=1.
  - On the first clken after break_req=0, tx returns to 1 and normal operation resumes. A break request during a frame waits until the frame ends.
- Undefined: port absent; idle line is always 1.

Decomposition:
- Package uart_tx_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP)
  - MIN_DATA_LEN=5
  - parity-type constants (PAR_EVEN=0, PAR_ODD=1)
  - stop-count constants
- Sub-module uart_tx_fifo:
  - synchronous FIFO, parametrised on width/depth
  - push/pop/full/empty/level
  - pop has priority for full-state acceptance

Test Plan:
- Default config (len=8, no parity, 1 stop), push 0xA5, cts_n=0 -> tx sequence 0,1,0,1,0,0,1,0,1,1, one bit per clken; stt_tx_done sets at the end; tx_busy is high for 10 ticks.
- len=7, parity odd, 2 stops, push 0x03 -> bits 0,1,1,0,0,0,0,0, parity 1, stops 1,1; total 11 ticks.
- DATA_WIDTH=9, len=9, even parity, push 0x1FF -> nine 1s, parity 1.
- Push 9 words into a depth-8 FIFO with cts_n=1 -> fifo_full=1, level=8, stt_overflow=1, tx stays 1. Release cts_n -> 8 frames sent back-to-back with no idle gap; fifo_empty at the end.
- Change cfg_data_len 8->5 mid-frame and raise cts_n mid-frame -> current frame still sends 8 bits and completes; next frame waits for cts_n=0 and uses len=5.
- Assert reset_n=0 during DATA -> tx=1 asynchronously, level=0, stt_tx_done=1. With UART_TX_BREAK_EN: break_req for 20 ticks -> tx=0 for 20 ticks, FIFO untouched.
